mnist_argmax_stream: RTL and testbench

//  Final classification stage of the MNIST inference datapath, downstream of the output (FC2) layer.

---
 rtl/mnist_argmax_stream.sv | 101 ++++++++++
 tb/tb_mnist_argmax_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_argmax_stream.sv
// Argmax stage after the FC2 layer: takes the class scores one beat at a time, keeps the running
// signed maximum, and reports the winning class with a one-cycle done pulse.
module mnist_argmax_stream #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 32,
  parameter int unsigned IDX_W       = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [SCORE_W-1:0] in_data_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic [IDX_W-1:0]   digit_o,
  output logic [SCORE_W-1:0] max_score_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   digit_q, digit_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               err_q, err_d;
  logic               at_last_idx;

  assign at_last_idx = (count_q == LastIdx);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    digit_d = digit_q;
    best_d  = best_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StAccum;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StAccum: begin
        // A restart wins over any beat presented in the same cycle.
        if (start_i) begin
          count_d = '0;
          err_d   = 1'b0;
        end else if (in_valid_i) begin
          if ((count_q == '0) || ($signed(in_data_i) > $signed(best_q))) begin
            best_d  = in_data_i;
            digit_d = count_q;
          end
          if (!at_last_idx) begin
            count_d = count_q + 1'b1;
          end
          if (in_last_i || at_last_idx) begin
            state_d = StDone;
            // Either a short vector or a full vector without its last flag.
            err_d   = in_last_i ^ at_last_idx;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      digit_q <= '0;
      best_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      digit_q <= digit_d;
      best_q  <= best_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o  = (state_q == StAccum);
  assign done_o      = (state_q == StDone);
  assign busy_o      = (state_q == StAccum) || (state_q == StDone);
  assign digit_o     = digit_q;
  assign max_score_o = best_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mnist_argmax_stream.sv
// Directed bench for mnist_argmax_stream: hand-computed argmax results, latency, error flag,
// restart and asynchronous reset behaviour.
module tb_mnist_argmax_stream;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [3:0]  digit;
  logic [31:0] max_score;
  logic        done;
  logic        busy;
  logic        err;

  int checks;
  int failures;
  logic done_prev;

  mnist_argmax_stream #(
    .NUM_CLASSES(10),
    .SCORE_W    (32),
    .IDX_W      (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .digit_o    (digit),
    .max_score_o(max_score),
    .done_o     (done),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // done must never stay high on two consecutive cycles.
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (done_prev) begin
        failures++;
        $display("FAIL done_width: done high on 2 consecutive cycles at %0t (required 1-cycle pulse)",
                 $time);
      end
    end
    done_prev = done;
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a negedge with the DUT in ACCUM; returns on the negedge after the final beat.
  task automatic send_vec(input logic [31:0] sc [10], input int n, input int last_at,
                          input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = sc[i];
      in_last  = (i == last_at);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    if (digit !== 4'd0) begin failures++; $display("FAIL reset_digit: got %0d want 0", digit); end
    if (max_score !== 32'd0) begin
      failures++; $display("FAIL reset_max: got %0h want 0", max_score);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v [10];
    v = '{5, -3, 7, 100, 2, 0, -50, 99, 1, 3};
    for (int g = 0; g < 2; g++) begin
      do_start();
      checks += 2;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b want 1", in_ready); end
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
      send_vec(v, 10, 9, g[0]);
      checks += 4;
      if (done !== 1'b1) begin failures++; $display("FAIL basic_done g=%0d: got %b want 1", g, done); end
      if (digit !== 4'd3) begin failures++; $display("FAIL basic_digit g=%0d: got %0d want 3", g, digit); end
      if (max_score !== 32'd100) begin
        failures++; $display("FAIL basic_max g=%0d: got %0d want 100", g, $signed(max_score));
      end
      if (err !== 1'b0) begin failures++; $display("FAIL basic_err g=%0d: got %b want 0", g, err); end
      @(negedge clk);
      checks += 3;
      if (done !== 1'b0) begin failures++; $display("FAIL basic_done_end: got %b want 0", done); end
      if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle: busy %b want 0", busy); end
      if (digit !== 4'd3) begin failures++; $display("FAIL basic_hold: got %0d want 3", digit); end
    end
  endtask

  task automatic test_tie();
    logic [31:0] v [10];
    v = '{-20, -20, -20, -20, -20, -20, -20, -20, -20, -20};
    do_start();
    send_vec(v, 10, 9, 1'b1);
    checks += 2;
    if (digit !== 4'd0) begin failures++; $display("FAIL tie_digit: got %0d want 0", digit); end
    if (max_score !== -32'sd20) begin
      failures++; $display("FAIL tie_max: got %0d want -20", $signed(max_score));
    end
    @(negedge clk);
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 999, 1000};
    do_start();
    send_vec(v, 10, 9, 1'b0);
    checks += 2;
    if (digit !== 4'd9) begin failures++; $display("FAIL last_idx_digit: got %0d want 9", digit); end
    if (max_score !== 32'd1000) begin
      failures++; $display("FAIL last_idx_max: got %0d want 1000", $signed(max_score));
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] v [10];
    v = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
          32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    do_start();
    send_vec(v, 10, 9, 1'b1);
    checks += 2;
    if (digit !== 4'd6) begin failures++; $display("FAIL signed_digit: got %0d want 6", digit); end
    if (max_score !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL signed_max: got %0h want ffffffff", max_score);
    end
    @(negedge clk);
  endtask

  task automatic test_short();
    logic [31:0] v [10];
    v = '{1, 2, 9, 3, 4, 0, 0, 0, 0, 0};
    do_start();
    send_vec(v, 5, 4, 1'b1);
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL short_done: got %b want 1", done); end
    if (digit !== 4'd2) begin failures++; $display("FAIL short_digit: got %0d want 2", digit); end
    if (max_score !== 32'd9) begin
      failures++; $display("FAIL short_max: got %0d want 9", $signed(max_score));
    end
    if (err !== 1'b1) begin failures++; $display("FAIL short_err: got %b want 1", err); end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL short_err_sticky: got %b want 1", err); end
    do_start();
    checks += 2;
    if (err !== 1'b0) begin failures++; $display("FAIL start_clears_err: got %b want 0", err); end
    if (digit !== 4'd2) begin failures++; $display("FAIL start_holds_digit: got %0d want 2", digit); end
    v = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 5};
    send_vec(v, 10, 9, 1'b0);
    checks += 2;
    if (digit !== 4'd8) begin failures++; $display("FAIL after_short_digit: got %0d want 8", digit); end
    if (err !== 1'b0) begin failures++; $display("FAIL after_short_err: got %b want 0", err); end
    @(negedge clk);
  endtask

  task automatic test_missing_last();
    logic [31:0] v [10];
    v = '{3, 3, 3, 3, 3, 3, 3, 4, 3, 3};
    do_start();
    send_vec(v, 10, -1, 1'b1);
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL nolast_done: got %b want 1", done); end
    if (digit !== 4'd7) begin failures++; $display("FAIL nolast_digit: got %0d want 7", digit); end
    if (err !== 1'b1) begin failures++; $display("FAIL nolast_err: got %b want 1", err); end
    @(negedge clk);
  endtask

  task automatic test_done_start();
    logic [31:0] v [10];
    v = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    do_start();
    send_vec(v, 10, 9, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_start_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL done_start_ready: got %b want 0", in_ready);
    end
    if (digit !== 4'd5) begin failures++; $display("FAIL done_start_digit: got %0d want 5", digit); end
  endtask

  task automatic test_restart();
    logic [31:0] v [10];
    v = '{7000, 8000, 9000, 9500, 9900, 0, 0, 0, 0, 0};
    do_start();
    send_vec(v, 5, -1, 1'b1);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL abort_no_done: got %b want 0", done); end
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b want 1", busy); end
    // Beat presented together with the restart must be dropped.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd10000;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL restart_no_done: got %b want 0", done); end
    v = '{10, 500, 20, 30, 40, 50, 60, 70, 80, 90};
    send_vec(v, 10, 9, 1'b1);
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL restart_done: got %b want 1", done); end
    if (digit !== 4'd1) begin failures++; $display("FAIL restart_digit: got %0d want 1", digit); end
    if (max_score !== 32'd500) begin
      failures++; $display("FAIL restart_max: got %0d want 500", $signed(max_score));
    end
    if (err !== 1'b0) begin failures++; $display("FAIL restart_err: got %b want 0", err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v [10];
    v = '{1, 50, 3, 0, 0, 0, 0, 0, 0, 0};
    do_start();
    send_vec(v, 3, -1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (digit !== 4'd0) begin failures++; $display("FAIL midrst_digit: got %0d want 0", digit); end
    if (max_score !== 32'd0) begin
      failures++; $display("FAIL midrst_max: got %0d want 0", $signed(max_score));
    end
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd77;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL postrst_ready: got %b want 0", in_ready);
      end
      if (done !== 1'b0) begin failures++; $display("FAIL postrst_done: got %b want 0", done); end
      if (digit !== 4'd0) begin failures++; $display("FAIL postrst_digit: got %0d want 0", digit); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_tie();
    test_signed();
    test_short();
    test_missing_last();
    test_done_start();
    test_restart();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
